// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the single-cycle ALU writeback (source A) and the
// buffered multi-cycle load/mul writeback (source B) onto the one register-file
// write port.
//
// Source B is held in a small FIFO. An A write marks older queued B writes to
// the same register stale, so the older B value can never overwrite the newer
// A value (WAW kill). A starvation counter stalls A for one cycle when the
// FIFO head has lost to A STARVE_LIMIT times in a row.
//
// Optional feature macro: WB_PENDING_MASK_EN. When defined, the block adds a
// registered 32-bit pending-destination mask on o_pending, which decode uses
// as a scoreboard.
module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  output logic        o_a_ready,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_ready,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
`ifdef WB_PENDING_MASK_EN
  output logic        o_idle,
  output logic [31:0] o_pending
`else
  output logic        o_idle
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  // FIFO state. The entries are register-based because every slot is
  // compared against the A address each cycle for the WAW kill.
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [DEPTH-1:0] stale_reg, stale_next;
  logic [DEPTH-1:0] slot_valid;
  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  // Starvation counter for the FIFO head.
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  // Registered write port.
  logic        we_reg, we_next;
  logic [4:0]  waddr_reg, waddr_next;
  logic [31:0] wdata_reg, wdata_next;

  // Per-cycle decision terms.
  logic head_valid;
  logic head_stale;
  logic head_live;
  logic starved;
  logic a_accept;
  logic a_write;
  logic head_write;
  logic stale_pop;
  logic pop;
  logic b_push;

  assign head_valid = (count_reg != '0);
  assign head_stale = stale_reg[rd_ptr_reg];
  assign head_live  = head_valid && !head_stale;

  // The head forces its way through once it has lost STARVE_LIMIT times.
  assign starved    = head_live && (starve_cnt_reg == STARVE_MAX);

  assign a_accept   = i_a_valid && !starved;
  // Address 0 is the hard-wired zero register: accepted, never written.
  assign a_write    = a_accept && (i_a_addr != 5'd0);

  // A live head uses the write port only when A is absent or held off.
  assign head_write = head_live && (starved || !i_a_valid);
  // A stale head is simply discarded, alongside whatever A is doing.
  assign stale_pop  = head_valid && head_stale;
  assign pop        = head_write || stale_pop;

  // No same-cycle pop credit: ready depends on the registered count only.
  assign o_b_ready  = (count_reg < DEPTH_CNT);
  assign o_a_ready  = !starved;

  // B writes to register 0 are accepted and dropped, never stored.
  assign b_push     = i_b_valid && o_b_ready && (i_b_addr != 5'd0);

  // Per-slot occupancy and stale-bit update.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] slot_off;
      logic             push_here;
      logic             kill_here;

      // A slot is occupied when it lies within count entries of the head.
      assign slot_off       = PTR_W'(gi) - rd_ptr_reg;
      assign slot_valid[gi] = ({1'b0, slot_off} < count_reg);

      assign push_here = b_push && (wr_ptr_reg == PTR_W'(gi));
      // A newer A write to the same register makes this queued B value dead.
      assign kill_here = a_write && slot_valid[gi] && (addr_mem[gi] == i_a_addr);

      // A B entry arriving alongside a same-register A write is born stale.
      assign stale_next[gi] = push_here ? (a_write && (i_a_addr == i_b_addr))
                                        : (stale_reg[gi] || kill_here);
    end
  endgenerate

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (b_push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({b_push, pop})
      2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
      2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Starvation tracking: count losses of a live head to A, clear on pop/empty.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!head_valid || pop) begin
      starve_cnt_next = '0;
    end else if (head_live && a_accept && (starve_cnt_reg != STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  // Write-port selection; address/data hold when nothing is written.
  always_comb begin
    we_next    = a_write || head_write;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    if (head_write) begin
      waddr_next = addr_mem[rd_ptr_reg];
      wdata_next = data_mem[rd_ptr_reg];
    end else if (a_write) begin
      waddr_next = i_a_addr;
      wdata_next = i_a_data;
    end
  end

  // Control state and registered write port, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      stale_reg      <= '0;
      starve_cnt_reg <= '0;
      we_reg         <= 1'b0;
      waddr_reg      <= 5'd0;
      wdata_reg      <= 32'd0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      stale_reg      <= stale_next;
      starve_cnt_reg <= starve_cnt_next;
      we_reg         <= we_next;
      waddr_reg      <= waddr_next;
      wdata_reg      <= wdata_next;
    end
  end

  // FIFO payload storage; contents only matter while a slot is occupied.
  always_ff @(posedge i_clk) begin
    if (b_push) begin
      addr_mem[wr_ptr_reg] <= i_b_addr;
      data_mem[wr_ptr_reg] <= i_b_data;
    end
  end

  assign o_we    = we_reg;
  assign o_waddr = waddr_reg;
  assign o_wdata = wdata_reg;
  assign o_idle  = (count_reg == '0) && !we_reg;

`ifdef WB_PENDING_MASK_EN
  // Destinations still owed to the register file after this edge: every
  // occupied, non-stale FIFO slot plus the write about to be issued.
  logic [DEPTH-1:0] slot_live_next;
  logic [4:0]       addr_next [DEPTH];
  logic [31:0]      pending_reg, pending_next;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pend
      logic [PTR_W-1:0] off_next;

      assign off_next           = PTR_W'(gi) - rd_ptr_next;
      assign slot_live_next[gi] = ({1'b0, off_next} < count_next) && !stale_next[gi];
      assign addr_next[gi]      = g_slot[gi].push_here ? i_b_addr : addr_mem[gi];
    end
  endgenerate

  // Build the scoreboard mask from the next-cycle FIFO and write port.
  always_comb begin
    pending_next = '0;
    if (we_next) begin
      pending_next[waddr_next] = 1'b1;
    end
    for (int s = 0; s < DEPTH; s++) begin
      if (slot_live_next[s]) begin
        pending_next[addr_next[s]] = 1'b1;
      end
    end
    pending_next[0] = 1'b0;
  end

  // Register the mask so decode sees a clean, glitch-free scoreboard.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign o_pending = pending_reg;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed testbench for wb_write_arbiter: hand-computed expectations for the
// A path, the B FIFO (fill, ordering, back-pressure), WAW kill, starvation
// guard, register-0 drops and reset mid-operation.
module tb_wb_write_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_a_valid = 1'b0;
  logic [4:0]  i_a_addr = 5'd0;
  logic [31:0] i_a_data = 32'd0;
  logic        o_a_ready;
  logic        i_b_valid = 1'b0;
  logic [4:0]  i_b_addr = 5'd0;
  logic [31:0] i_b_data = 32'd0;
  logic        o_b_ready;
  logic        o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        o_idle;
`ifdef WB_PENDING_MASK_EN
  logic [31:0] o_pending;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  wb_write_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_a_valid (i_a_valid),
    .i_a_addr  (i_a_addr),
    .i_a_data  (i_a_data),
    .o_a_ready (o_a_ready),
    .i_b_valid (i_b_valid),
    .i_b_addr  (i_b_addr),
    .i_b_data  (i_b_data),
    .o_b_ready (o_b_ready),
    .o_we      (o_we),
    .o_waddr   (o_waddr),
    .o_wdata   (o_wdata),
`ifdef WB_PENDING_MASK_EN
    .o_idle    (o_idle),
    .o_pending (o_pending)
`else
    .o_idle    (o_idle)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] a, input logic [31:0] d);
    i_a_valid = v;
    i_a_addr  = a;
    i_a_data  = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] a, input logic [31:0] d);
    i_b_valid = v;
    i_b_addr  = a;
    i_b_data  = d;
  endtask

  initial begin
    // Reset state
    step();
    step();
    i_rst = 1'b0;
    chk("rst_we",     {31'd0, o_we},     32'd0);
    chk("rst_waddr",  {27'd0, o_waddr},  32'd0);
    chk("rst_wdata",  o_wdata,           32'd0);
    chk("rst_idle",   {31'd0, o_idle},   32'd1);
    chk("rst_aready", {31'd0, o_a_ready}, 32'd1);
    chk("rst_bready", {31'd0, o_b_ready}, 32'd1);

    // Single A write, one-cycle latency
    set_a(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    chk("a1_we",    {31'd0, o_we},    32'd1);
    chk("a1_waddr", {27'd0, o_waddr}, 32'd5);
    chk("a1_wdata", o_wdata,          32'hDEADBEEF);
    chk("a1_idle",  {31'd0, o_idle},  32'd0);
    step();
    chk("a1_we_off",   {31'd0, o_we},    32'd0);
    chk("a1_hold_adr", {27'd0, o_waddr}, 32'd5);
    chk("a1_idle2",    {31'd0, o_idle},  32'd1);

    // Single B write, two edges after transfer
    set_b(1'b1, 5'd7, 32'h11);
    chk("b1_bready", {31'd0, o_b_ready}, 32'd1);
    step();
    set_b(1'b0, 5'd0, 32'd0);
    chk("b1_we_e1",  {31'd0, o_we},   32'd0);
    chk("b1_idle_q", {31'd0, o_idle}, 32'd0);
`ifdef WB_PENDING_MASK_EN
    chk("b1_pend", o_pending, 32'h0000_0080);
`endif
    step();
    chk("b1_we",    {31'd0, o_we},    32'd1);
    chk("b1_waddr", {27'd0, o_waddr}, 32'd7);
    chk("b1_wdata", o_wdata,          32'h11);
    step();
    chk("b1_we_off", {31'd0, o_we},   32'd0);
    chk("b1_idle",   {31'd0, o_idle}, 32'd1);

    // Fill the FIFO while A (addr 0) keeps the head from popping
    set_a(1'b1, 5'd0, 32'h0);
    set_b(1'b1, 5'd3, 32'hA);
    step();
    set_b(1'b1, 5'd4, 32'hB);
    chk("f_bready1", {31'd0, o_b_ready}, 32'd1);
    step();
    chk("f_full",   {31'd0, o_b_ready}, 32'd0);
    chk("f_we0",    {31'd0, o_we},      32'd0);
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b1, 5'd8, 32'hC);
    step();
    chk("f_w1_we",    {31'd0, o_we},      32'd1);
    chk("f_w1_waddr", {27'd0, o_waddr},   32'd3);
    chk("f_w1_wdata", o_wdata,            32'hA);
    chk("f_bready2",  {31'd0, o_b_ready}, 32'd1);
    step();
    set_b(1'b0, 5'd0, 32'd0);
    chk("f_w2_waddr", {27'd0, o_waddr}, 32'd4);
    chk("f_w2_wdata", o_wdata,          32'hB);
    step();
    chk("f_w3_we",    {31'd0, o_we},    32'd1);
    chk("f_w3_waddr", {27'd0, o_waddr}, 32'd8);
    chk("f_w3_wdata", o_wdata,          32'hC);
    step();
    chk("f_we_off", {31'd0, o_we},   32'd0);
    chk("f_idle",   {31'd0, o_idle}, 32'd1);

    // WAW kill: queued B to r9 overtaken by A to r9
    set_b(1'b1, 5'd9, 32'h1);
    step();
    set_b(1'b0, 5'd0, 32'd0);
    set_a(1'b1, 5'd9, 32'h2);
    chk("k_aready", {31'd0, o_a_ready}, 32'd1);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    chk("k_we",    {31'd0, o_we},    32'd1);
    chk("k_waddr", {27'd0, o_waddr}, 32'd9);
    chk("k_wdata", o_wdata,          32'h2);
    step();
    chk("k_stale_we",  {31'd0, o_we},   32'd0);
    chk("k_stale_dat", o_wdata,         32'h2);
    chk("k_idle",      {31'd0, o_idle}, 32'd1);

    // Starvation guard: head loses four times, fifth cycle A is held off
    set_a(1'b1, 5'd10, 32'h100);
    set_b(1'b1, 5'd6, 32'h55);
    step();
    set_b(1'b0, 5'd0, 32'd0);
    chk("s_a0_waddr", {27'd0, o_waddr}, 32'd10);
    for (int k = 1; k <= 4; k++) begin
      set_a(1'b1, 5'(10 + k), 32'h100 + 32'(k));
      chk($sformatf("s_aready%0d", k), {31'd0, o_a_ready}, 32'd1);
      step();
      chk($sformatf("s_a%0d_waddr", k), {27'd0, o_waddr}, 32'(10 + k));
    end
    set_a(1'b1, 5'd15, 32'h105);
    chk("s_starved", {31'd0, o_a_ready}, 32'd0);
    step();
    chk("s_b_we",    {31'd0, o_we},      32'd1);
    chk("s_b_waddr", {27'd0, o_waddr},   32'd6);
    chk("s_b_wdata", o_wdata,            32'h55);
    chk("s_resume",  {31'd0, o_a_ready}, 32'd1);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    chk("s_a5_waddr", {27'd0, o_waddr}, 32'd15);
    chk("s_a5_wdata", o_wdata,          32'h105);
    step();
    chk("s_idle", {31'd0, o_idle}, 32'd1);

    // Register-0 writes from both sources are accepted and dropped
    set_a(1'b1, 5'd0, 32'hFF);
    set_b(1'b1, 5'd0, 32'hFF);
    chk("z_aready", {31'd0, o_a_ready}, 32'd1);
    chk("z_bready", {31'd0, o_b_ready}, 32'd1);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    chk("z_we1",  {31'd0, o_we},   32'd0);
    chk("z_idle", {31'd0, o_idle}, 32'd1);
    step();
    chk("z_we2", {31'd0, o_we}, 32'd0);

    // Reset with two entries queued discards them
    set_a(1'b1, 5'd0, 32'h0);
    set_b(1'b1, 5'd12, 32'h1);
    step();
    set_b(1'b1, 5'd13, 32'h2);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    chk("r_full", {31'd0, o_b_ready}, 32'd0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("r_we",     {31'd0, o_we},      32'd0);
    chk("r_bready", {31'd0, o_b_ready}, 32'd1);
    chk("r_idle",   {31'd0, o_idle},    32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("r_post_we%0d", k), {31'd0, o_we}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Merges two writeback producers into the single register-file write port (o_we/o_waddr/o_wdata drive regFile i_we/i_waddr/i_wdata).
- Source A is the single-cycle ALU path. Source B is the multi-cycle load/mul path, buffered in a small FIFO.
- Issues at most one register write per cycle, with WAW kill of stale buffered B writes and a starvation guard for B.

Parameters:
DEPTH, 2, B-side FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, cycles a valid FIFO head may lose to A before A is stalled one cycle
CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_a_valid  in  1  source A write request
i_a_addr  in  5  source A destination register
i_a_data  in  32  source A write data
o_a_ready  out  1  source A accepted this cycle when high with i_a_valid
i_b_valid  in  1  source B write request
i_b_addr  in  5  source B destination register
i_b_data  in  32  source B write data
o_b_ready  out  1  FIFO has space; B transfer when i_b_valid && o_b_ready
o_we  out  1  register-file write enable (registered)
o_waddr  out  5  register-file write address (registered)
o_wdata  out  32  register-file write data (registered)
o_idle  out  1  FIFO empty and o_we low

Behaviour:
- Reset (i_rst high at edge): FIFO count/pointers, stale bits and starvation counter go to 0. o_we=0, o_waddr=0, o_wdata=0, o_idle=1. Reset mid-operation discards all queued B entries; no write issues in the following cycle.
- Combinational: o_b_ready = (count < DEPTH); no same-cycle pop credit. o_a_ready = !(head valid && !head stale && starve_cnt == STARVE_LIMIT).
- Per-cycle selection, decided at the start of the cycle:
  - Starved: o_a_ready=0; FIFO head written; A held off.
  - Else if i_a_valid: A accepted. If i_a_addr != 0, A written; i_a_addr == 0 is accepted and dropped.
  - Else if head valid and not stale: head written and popped.
- Stale head pops in any cycle without using the write port, in parallel with an A write. It never drives o_we.
- Output latency is 1 cycle. The selected write appears on o_we/o_waddr/o_wdata at the next edge. When no write is selected, o_we=0 and o_waddr/o_wdata hold their previous values.
- B enqueue: a B transfer with i_b_addr == 0 is accepted but not stored. Otherwise the entry is stored at the tail, earliest written one cycle after enqueue (o_we two edges after transfer).
- WAW kill: B writes are older than concurrent and later A writes.
  - Every accepted A write with addr != 0 sets the stale bit of each valid FIFO entry with an equal addr.
  - A B entry enqueued in the same cycle as an accepted A write to the same address is enqueued stale.
  - Two B entries to the same register both write, in FIFO order.
- Starvation counter:
  - Increments each cycle the head is valid, not stale, and loses to A.
  - Clears on head pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Full FIFO: o_b_ready=0. A pop in that cycle does not raise ready until the next cycle.
- Simultaneous enqueue and pop: count unchanged, pointers both advance with wrap-around modulo DEPTH.

Optional Feature:
WB_PENDING_MASK_EN
- Defined: adds output o_pending[31:0], registered. Bit r is high while any valid non-stale FIFO entry or the in-flight o_we write targets r. Bit 0 is always 0. Reset value 0. The decode stage uses it as a scoreboard.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then A {addr 5, data 0xDEADBEEF} one cycle -> next cycle o_we=1, o_waddr=5, o_wdata=0xDEADBEEF; following cycle o_we=0.
- B {addr 7, 0x11} with A idle -> o_b_ready=1; o_we=1/waddr=7/wdata=0x11 two edges after transfer; o_idle returns to 1.
- B fills FIFO {3,0xA},{4,0xB} -> o_b_ready=0; third B held until the first pop; order on o_waddr is 3, 4, then the third.
- B {9,0x1} enqueued, then A {9,0x2} -> only one write, waddr=9, wdata=0x2; stale entry popped with no o_we.
- A valid every cycle with B {6,0x55} queued -> head loses 4 cycles, 5th cycle o_a_ready=0, o_we/waddr=6/0x55 next edge, A resumes after.
- A {0,0xFF} and B {0,0xFF} -> both accepted, o_we never asserts; assert i_rst with 2 queued entries -> no writes afterward, o_b_ready=1.
